// File: rtl/dbf_sum_tree.sv
// dbf_sum_tree: aligned multi-channel beam summer with pipelined adder tree and line counter; DBF_SUM_CH_MASK_EN adds per-channel masking
module dbf_sum_tree #(
    parameter int  NUM_CH   = 16,
    parameter int  IN_WD    = 32,
    parameter int  LINE_LEN = 2048,
    localparam int LVL      = $clog2(NUM_CH),
    localparam int SUM_WD   = IN_WD + LVL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_CH*IN_WD-1:0]  ch_din,
    input  logic [NUM_CH-1:0]        ch_din_valid,
`ifdef DBF_SUM_CH_MASK_EN
    input  logic [NUM_CH-1:0]        ch_mask,
`endif
    output logic signed [SUM_WD-1:0] sum_dout,
    output logic                     sum_dout_valid,
    output logic                     line_done,
    output logic                     err_misalign
);
    localparam logic [15:0] LAST = 16'(LINE_LEN - 1);

    logic [NUM_CH-1:0]        w_act;
    logic [NUM_CH-1:0]        w_v;
    logic                     w_all;
    logic                     w_mix;
    logic                     w_rise;
    logic                     r_start_d;
    logic                     r_err;
    logic                     r_vout;
    logic                     r_line_done;
    logic [15:0]              r_cnt;
    logic signed [SUM_WD-1:0] r_sum;

`ifdef DBF_SUM_CH_MASK_EN
    assign w_act = ~ch_mask;
`else
    assign w_act = '1;
`endif
    assign w_v    = ch_din_valid & w_act;
    assign w_all  = (w_act != '0) && (w_v == w_act);
    assign w_mix  = (w_v != '0) && (w_v != w_act);
    assign w_rise = start & ~r_start_d;

    for (genvar j = 0; j <= LVL; j++) begin : g_l
        localparam int N = NUM_CH >> j;
        localparam int W = IN_WD + j;
        logic [N*W-1:0] r_d;
        logic           r_v;
        if (j == 0) begin : g_in
            // Stage 0: accept aligned sets while start is high, zeroing inactive channels
            always_ff @(posedge clk) begin
                r_v <= rst_n ? 1'b0 : (start & w_all);
                for (int i = 0; i < N; i++)
                    r_d[i*W +: W] <= w_act[i] ? ch_din[i*W +: W] : '0;
            end
        end else begin : g_add
            // Level j: sum adjacent pairs of the previous level, one bit wider so nothing overflows
            always_ff @(posedge clk) begin
                r_v <= rst_n ? 1'b0 : g_l[j-1].r_v;
                for (int i = 0; i < N; i++)
                    r_d[i*W +: W] <= {g_l[j-1].r_d[2*i*(W-1)+W-2], g_l[j-1].r_d[2*i*(W-1) +: W-1]}
                                   + {g_l[j-1].r_d[(2*i+1)*(W-1)+W-2], g_l[j-1].r_d[(2*i+1)*(W-1) +: W-1]};
            end
        end
    end

    // Output register, per-line sample counter (a start rise clears it last) and sticky misalignment flag
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_start_d   <= 1'b0;
            r_err       <= 1'b0;
            r_vout      <= 1'b0;
            r_line_done <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
        end else begin
            r_start_d   <= start;
            r_vout      <= g_l[LVL].r_v;
            r_line_done <= g_l[LVL].r_v && (r_cnt == LAST);
            r_sum       <= g_l[LVL].r_v ? g_l[LVL].r_d : r_sum;
            r_cnt       <= w_rise ? '0 : !g_l[LVL].r_v ? r_cnt : (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            r_err       <= (start & w_mix) | (r_err & ~w_rise);
        end
    end

    assign sum_dout       = r_sum;
    assign sum_dout_valid = r_vout;
    assign line_done      = r_line_done;
    assign err_misalign   = r_err;
endmodule

// File: tb/tb_dbf_sum_tree.sv
// tb_dbf_sum_tree: randomized self-checking bench for dbf_sum_tree against an array-based reference model
module tb_dbf_sum_tree;
    localparam int NC   = 16;
    localparam int IW   = 32;
    localparam int LL   = 4;
    localparam int SW   = 36;
    localparam int LAT  = 5;
    localparam int MAXC = 64;
`ifdef DBF_SUM_CH_MASK_EN
    localparam logic [NC-1:0] MASK_ON = '1;
`else
    localparam logic [NC-1:0] MASK_ON = '0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic [NC*IW-1:0]     ch_din = '0;
    logic [NC-1:0]        ch_din_valid = '0;
`ifdef DBF_SUM_CH_MASK_EN
    logic [NC-1:0]        ch_mask = '0;
`endif
    logic signed [SW-1:0] sum_dout;
    logic                 sum_dout_valid;
    logic                 line_done;
    logic                 err_misalign;

    int n_checks = 0;
    int n_err = 0;

    logic             st_start [MAXC];
    logic [NC-1:0]    st_val   [MAXC];
    logic [NC-1:0]    st_mask  [MAXC];
    logic [NC*IW-1:0] st_d     [MAXC];
    logic             ob_v [MAXC], ob_ld [MAXC], ob_err [MAXC];
    logic             ex_v [MAXC], ex_ld [MAXC], ex_err [MAXC];
    logic signed [SW-1:0] ob_s [MAXC], ex_s [MAXC];

    int                   m_cnt = 0;
    logic                 m_prev = 1'b0;
    logic                 m_err = 1'b0;
    logic signed [SW-1:0] m_sum = '0;

    always #5 clk = ~clk;

    dbf_sum_tree #(.NUM_CH(NC), .IN_WD(IW), .LINE_LEN(LL)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ch_din(ch_din),
        .ch_din_valid(ch_din_valid),
`ifdef DBF_SUM_CH_MASK_EN
        .ch_mask(ch_mask),
`endif
        .sum_dout(sum_dout),
        .sum_dout_valid(sum_dout_valid),
        .line_done(line_done),
        .err_misalign(err_misalign)
    );

    function automatic logic [NC-1:0] act(input int t);
        return ~(st_mask[t] & MASK_ON);
    endfunction

    task automatic clear_stim();
        for (int t = 0; t < MAXC; t++) begin
            st_start[t] = 1'b0;
            st_val[t]   = '0;
            st_mask[t]  = '0;
            st_d[t]     = '0;
        end
    endtask

    task automatic rand_data(input int t);
        for (int k = 0; k < NC; k++)
            st_d[t][k*IW +: IW] = $urandom();
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) begin
            start        = st_start[t];
            ch_din_valid = st_val[t];
            ch_din       = st_d[t];
`ifdef DBF_SUM_CH_MASK_EN
            ch_mask      = st_mask[t];
`endif
            @(posedge clk);
            #1;
            ob_v[t]   = sum_dout_valid;
            ob_s[t]   = sum_dout;
            ob_ld[t]  = line_done;
            ob_err[t] = err_misalign;
        end
        start        = 1'b0;
        ch_din_valid = '0;
    endtask

    task automatic predict(input int n);
        logic                 pv [MAXC];
        logic signed [SW-1:0] ps [MAXC];
        logic [NC-1:0]        a, v;
        longint               s;
        logic                 rise, ld;
        for (int t = 0; t < MAXC; t++) begin
            pv[t] = 1'b0;
            ps[t] = '0;
        end
        for (int t = 0; t < n; t++) begin
            a    = act(t);
            v    = st_val[t] & a;
            rise = st_start[t] && !m_prev;
            if (st_start[t] && a != '0 && v == a && t + LAT < MAXC) begin
                s = 0;
                for (int k = 0; k < NC; k++)
                    if (a[k]) s += longint'($signed(st_d[t][k*IW +: IW]));
                pv[t+LAT] = 1'b1;
                ps[t+LAT] = SW'(s);
            end
            ld = 1'b0;
            if (pv[t]) begin
                m_sum = ps[t];
                m_cnt++;
                ld = (m_cnt == LL);
                if (ld) m_cnt = 0;
            end
            if (rise) m_cnt = 0;
            if (st_start[t] && v != '0 && v != a) m_err = 1'b1;
            else if (rise) m_err = 1'b0;
            ex_v[t]   = pv[t];
            ex_s[t]   = m_sum;
            ex_ld[t]  = ld;
            ex_err[t] = m_err;
            m_prev    = st_start[t];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sum_dout !== '0) begin n_err++; $display("FAIL reset_sum got %0d want 0", sum_dout); end
        n_checks++;
        if (sum_dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", sum_dout_valid); end
        n_checks++;
        if (line_done !== 1'b0) begin n_err++; $display("FAIL reset_line_done got %b want 0", line_done); end
        n_checks++;
        if (err_misalign !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err_misalign); end
        rst_n = 1'b0;
    endtask

    task automatic test_basic();
        clear_stim();
        st_start[0] = 1'b1;
        st_val[0]   = '1;
        st_d[0]     = {NC{32'd1000}};
        run(12);
        predict(12);
        n_checks++;
        if (ob_v[LAT] !== 1'b1 || ob_s[LAT] !== 36'sd16000)
            begin n_err++; $display("FAIL basic_sum got v=%b sum=%0d want v=1 sum=16000", ob_v[LAT], ob_s[LAT]); end
        for (int t = 0; t < 12; t++) begin
            n_checks++;
            if ({ob_v[t], ob_ld[t], ob_err[t], ob_s[t]} !== {ex_v[t], ex_ld[t], ex_err[t], ex_s[t]}) begin
                n_err++;
                $display("FAIL basic t=%0d got v=%b ld=%b err=%b sum=%0d want v=%b ld=%b err=%b sum=%0d",
                         t, ob_v[t], ob_ld[t], ob_err[t], ob_s[t], ex_v[t], ex_ld[t], ex_err[t], ex_s[t]);
            end
        end
    endtask

    task automatic test_extremes();
        clear_stim();
        st_start[0] = 1'b1;
        st_start[1] = 1'b1;
        st_val[0]   = '1;
        st_val[1]   = '1;
        st_d[0]     = {NC{32'h8000_0000}};
        st_d[1]     = {NC{32'h7FFF_FFFF}};
        run(12);
        predict(12);
        n_checks++;
        if (ob_s[LAT] !== 36'sh8_0000_0000)
            begin n_err++; $display("FAIL extreme_min got %0d want %0d", ob_s[LAT], 36'sh8_0000_0000); end
        n_checks++;
        if (ob_s[LAT+1] !== 36'sh7_FFFF_FFF0)
            begin n_err++; $display("FAIL extreme_max got %0d want %0d", ob_s[LAT+1], 36'sh7_FFFF_FFF0); end
        for (int t = 0; t < 12; t++) begin
            n_checks++;
            if ({ob_v[t], ob_ld[t], ob_err[t], ob_s[t]} !== {ex_v[t], ex_ld[t], ex_err[t], ex_s[t]}) begin
                n_err++;
                $display("FAIL extremes t=%0d got v=%b ld=%b err=%b sum=%0d want v=%b ld=%b err=%b sum=%0d",
                         t, ob_v[t], ob_ld[t], ob_err[t], ob_s[t], ex_v[t], ex_ld[t], ex_err[t], ex_s[t]);
            end
        end
    endtask

    task automatic test_misalign();
        clear_stim();
        for (int t = 0; t < 3; t++) begin
            st_start[t] = 1'b1;
            st_val[t]   = '1;
            rand_data(t);
        end
        st_val[1][3] = 1'b0;
        run(12);
        predict(12);
        n_checks++;
        if (ob_v[LAT+1] !== 1'b0) begin n_err++; $display("FAIL misalign_drop got v=%b want 0", ob_v[LAT+1]); end
        n_checks++;
        if (ob_err[11] !== 1'b1) begin n_err++; $display("FAIL misalign_sticky got %b want 1", ob_err[11]); end
        for (int t = 0; t < 12; t++) begin
            n_checks++;
            if ({ob_v[t], ob_ld[t], ob_err[t], ob_s[t]} !== {ex_v[t], ex_ld[t], ex_err[t], ex_s[t]}) begin
                n_err++;
                $display("FAIL misalign t=%0d got v=%b ld=%b err=%b sum=%0d want v=%b ld=%b err=%b sum=%0d",
                         t, ob_v[t], ob_ld[t], ob_err[t], ob_s[t], ex_v[t], ex_ld[t], ex_err[t], ex_s[t]);
            end
        end
    endtask

    task automatic test_line_count();
        int n_ld;
        clear_stim();
        for (int t = 0; t < 10; t++) begin
            st_start[t] = 1'b1;
            st_val[t]   = '1;
            rand_data(t);
        end
        run(18);
        predict(18);
        n_ld = 0;
        for (int t = 0; t < 18; t++) n_ld += int'(ob_ld[t]);
        n_checks++;
        if (n_ld != 2 || ob_ld[LAT+3] !== 1'b1 || ob_ld[LAT+7] !== 1'b1)
            begin n_err++; $display("FAIL line_done_count got %0d pulses (o4=%b o8=%b) want 2", n_ld, ob_ld[LAT+3], ob_ld[LAT+7]); end
        for (int t = 0; t < 18; t++) begin
            n_checks++;
            if ({ob_v[t], ob_ld[t], ob_err[t], ob_s[t]} !== {ex_v[t], ex_ld[t], ex_err[t], ex_s[t]}) begin
                n_err++;
                $display("FAIL line t=%0d got v=%b ld=%b err=%b sum=%0d want v=%b ld=%b err=%b sum=%0d",
                         t, ob_v[t], ob_ld[t], ob_err[t], ob_s[t], ex_v[t], ex_ld[t], ex_err[t], ex_s[t]);
            end
        end
        clear_stim();
        for (int t = 0; t < 4; t++) begin
            st_start[t] = 1'b1;
            st_val[t]   = '1;
            rand_data(t);
        end
        run(12);
        predict(12);
        n_checks++;
        if (ob_ld[LAT+3] !== 1'b1 || ob_ld[LAT+2] !== 1'b0)
            begin n_err++; $display("FAIL line_restart got o3=%b o4=%b want o3=0 o4=1", ob_ld[LAT+2], ob_ld[LAT+3]); end
        for (int t = 0; t < 12; t++) begin
            n_checks++;
            if ({ob_v[t], ob_ld[t], ob_err[t], ob_s[t]} !== {ex_v[t], ex_ld[t], ex_err[t], ex_s[t]}) begin
                n_err++;
                $display("FAIL line2 t=%0d got v=%b ld=%b err=%b sum=%0d want v=%b ld=%b err=%b sum=%0d",
                         t, ob_v[t], ob_ld[t], ob_err[t], ob_s[t], ex_v[t], ex_ld[t], ex_err[t], ex_s[t]);
            end
        end
    endtask

    task automatic test_random();
        clear_stim();
        for (int t = 0; t < 40; t++) begin
            st_start[t] = ($urandom_range(3) != 0);
            st_val[t]   = ($urandom_range(4) == 0) ? NC'($urandom()) : '1;
            st_mask[t]  = ($urandom_range(3) == 0) ? NC'($urandom()) : '0;
            rand_data(t);
        end
        run(48);
        predict(48);
        for (int t = 0; t < 48; t++) begin
            n_checks++;
            if ({ob_v[t], ob_ld[t], ob_err[t], ob_s[t]} !== {ex_v[t], ex_ld[t], ex_err[t], ex_s[t]}) begin
                n_err++;
                $display("FAIL random t=%0d got v=%b ld=%b err=%b sum=%0d want v=%b ld=%b err=%b sum=%0d",
                         t, ob_v[t], ob_ld[t], ob_err[t], ob_s[t], ex_v[t], ex_ld[t], ex_err[t], ex_s[t]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 3; t++) begin
            start        = 1'b1;
            ch_din_valid = '1;
            for (int k = 0; k < NC; k++) ch_din[k*IW +: IW] = $urandom();
            @(posedge clk);
            #1;
        end
        start        = 1'b0;
        ch_din_valid = '0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        n_checks++;
        if ({sum_dout_valid, line_done, err_misalign, sum_dout} !== '0)
            begin n_err++; $display("FAIL reset_mid_outputs got v=%b ld=%b err=%b sum=%0d want all 0", sum_dout_valid, line_done, err_misalign, sum_dout); end
        for (int t = 0; t < 8; t++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (sum_dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid_ghost t=%0d got v=%b want 0", t, sum_dout_valid); end
        end
        m_cnt  = 0;
        m_prev = 1'b0;
        m_err  = 1'b0;
        m_sum  = '0;
    endtask

`ifdef DBF_SUM_CH_MASK_EN
    task automatic test_mask();
        clear_stim();
        st_start[0] = 1'b1;
        st_val[0]   = 16'hFFF0;
        st_mask[0]  = 16'h000F;
        for (int k = 0; k < NC; k++) st_d[0][k*IW +: IW] = 32'(k + 1);
        run(12);
        predict(12);
        n_checks++;
        if (ob_v[LAT] !== 1'b1 || ob_s[LAT] !== 36'sd126 || ob_err[LAT] !== 1'b0)
            begin n_err++; $display("FAIL mask_sum got v=%b sum=%0d err=%b want v=1 sum=126 err=0", ob_v[LAT], ob_s[LAT], ob_err[LAT]); end
        for (int t = 0; t < 12; t++) begin
            n_checks++;
            if ({ob_v[t], ob_ld[t], ob_err[t], ob_s[t]} !== {ex_v[t], ex_ld[t], ex_err[t], ex_s[t]}) begin
                n_err++;
                $display("FAIL mask t=%0d got v=%b ld=%b err=%b sum=%0d want v=%b ld=%b err=%b sum=%0d",
                         t, ob_v[t], ob_ld[t], ob_err[t], ob_s[t], ex_v[t], ex_ld[t], ex_err[t], ex_s[t]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_misalign();
        test_line_count();
        test_random();
        test_reset_mid();
`ifdef DBF_SUM_CH_MASK_EN
        test_mask();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/dbf_sum_tree.md
# dbf_sum_tree

Receive-path beam summer that sits directly downstream of the per-channel DBF stages (dbf_ch0 … dbf_chN-1). It takes the apodised 32-bit channel outputs and their valid strobes, checks that all channels are aligned, and adds the channels in a fully pipelined binary adder tree. It emits one beamformed sample per aligned input set and counts samples per receive line.

## Interface
Parameters:
- NUM_CH, 16: number of channels; must be a power of two, 2 to 64.
- IN_WD, 32: width of each signed channel sample.
- LINE_LEN, 2048: output samples per receive line; range 1 to 65535.
- LVL, log2(NUM_CH): number of adder levels (derived localparam).
- SUM_WD, IN_WD+LVL: output width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. The codebase port name is kept, but this reset is synchronous and active-high.
- start  in  1  receive-line enable; same signal as the channel stages.
- ch_din  in  NUM_CH*IN_WD  packed signed channel samples; channel k is at [k*IN_WD +: IN_WD].
- ch_din_valid  in  NUM_CH  per-channel valid; bit k is dbf_ch_doutk_valid.
- sum_dout  out  SUM_WD  signed beamformed sample.
- sum_dout_valid  out  1  sum_dout is valid this cycle.
- line_done  out  1  one-cycle pulse coincident with the LINE_LEN-th valid output of a line.
- err_misalign  out  1  sticky flag: channel valids disagreed.

## Operation
Input qualify (stage 0):
- Active set: all channels, or only unmasked channels when DBF_SUM_CH_MASK_EN is defined.
- Aligned set: every active valid bit is 1. The set is accepted only when start is 1; accepted samples are registered with valid = 1.
- Mixed active valid bits with start = 1:
  - that set is dropped (stage-0 valid = 0);
  - err_misalign is set.
- All active valid bits 0: idle, no error.
- start = 0: inputs ignored, no error check.

Adder tree (stages 1..LVL):
- Level j adds adjacent pairs, sign-extended by one bit per level. No truncation and no overflow: SUM_WD holds the worst case.
- Each level is registered. The valid bit travels with the data.
- The pipeline always drains, even after start falls.

Output:
- sum_dout and sum_dout_valid are registered after level LVL.
- When sum_dout_valid = 0, sum_dout holds its last value.

Line counter (16 bits):
- Increments on each sum_dout_valid.
- On the LINE_LEN-th valid: line_done = 1, counter returns to 0.
- A rising edge of start (start = 1, previous start = 0):
  - clears the counter and err_misalign;
  - does not flush samples already in the pipeline.

## Timing
- Latency: input set on edge n gives sum_dout_valid on edge n+LVL+1. Default is 5 cycles.
- Throughput: one set per clock. No backpressure; downstream must accept every valid.
- Reset (rst_n = 1, sampled on a clk edge):
  - sum_dout = 0, sum_dout_valid = 0, line_done = 0, err_misalign = 0;
  - all pipeline valids = 0, counter = 0, previous-start register = 0.
- Reset mid-line discards in-flight samples. No output appears for them.
- Counter wrap and start rising in the same cycle: the start clear wins. line_done still pulses if that output was the LINE_LEN-th.
- Misaligned set in the same cycle as the start rising edge: err_misalign ends at 1 (set has priority over clear).
- LINE_LEN = 1: line_done pulses on every valid output.

## Configuration
DBF_SUM_CH_MASK_EN
- Defined:
  - adds input port ch_mask, NUM_CH bits, registered into stage 0;
  - a masked bit forces that channel's sample to 0 before level 1;
  - a masked channel's valid is excluded from the alignment check;
  - all channels masked: no output valids are produced.
- Not defined:
  - the port is absent;
  - every channel is active and its valid is required.

## Test plan
- Basic sum: NUM_CH = 16, every channel = 1000, all valid, start = 1 for one cycle. Expect sum_dout = 16000 with valid exactly 5 cycles later, and no other valids.
- Sign/width extremes: all channels = -2^31. Expect sum_dout = -2^35 (36-bit, no wrap). Then all channels = 2^31-1. Expect 2^35-16.
- Misalignment: channel 3 valid low for one cycle while the others are high. Expect:
  - that set is missing from the output;
  - err_misalign = 1 until the next start rising edge;
  - neighbouring sets are summed correctly.
- Line count: LINE_LEN = 4, start held, 10 continuous valid sets. Expect line_done on outputs 4 and 8 only. Then drop start and raise it again; the next line_done is on the 4th output after that.
- Reset mid-stream: assert rst_n = 1 for one cycle while 3 sets are in flight. Expect all outputs = 0 the next cycle and no delayed valids.
- Mask (DBF_SUM_CH_MASK_EN): ch_mask = 0x000F, channel k = k+1, channels 0–3 valid forced 0. Expect:
  - sum_dout = sum of 5..16 = 126;
  - err_misalign stays 0.
